// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for a glitch-free integer clock divider on clk_in
//   clk_in    : the single clock, all logic on posedge
//   rst       : async reset, active-high
//   en        : 1 = run, 0 = stop at the end of the current period
//   cfg_valid : new ratio offered
//   cfg_div   : offered ratio N (legal 2..2^CNT_W-1)
//   cfg_ready : ratio can be accepted (no change pending)
//   clk_out   : divided clock, flop-driven
//   div_tick  : pulse in the last clk_in cycle of each period
//   busy      : divider running or draining
//   cur_div   : ratio of the period now running
//   cfg_err   : pulse after an illegal ratio (<2) was offered
module clk_div_ctrl #(
  parameter int CNT_W = 8,
  parameter int DEF_DIV = 5
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             div_tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div,
  output logic             cfg_err
);
  localparam logic [1:0] STOP = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0] state, nstate;
  logic [CNT_W-1:0] cnt, ncnt, ndiv, pend_div;
  logic [CNT_W:0] h;
  logic pend, run, last, acc, acc_ok;
  assign cfg_ready = !pend;
  assign busy = state != STOP;
  assign run = state != STOP;
  assign last = run && cnt == cur_div - 1'b1;
  assign acc = cfg_valid && cfg_ready;
  assign acc_ok = acc && cfg_div >= CNT_W'(2);
  // Outputs are registered from the next-cycle state/count/ratio, so each
  // flop output describes the cycle it is visible in with no comb path.
  always_comb begin
    nstate = state == STOP ? (en ? RUN : STOP) :
             state == RUN ? (en ? RUN : DRAIN) :
             en ? RUN : (last ? STOP : DRAIN);
    ncnt = run && !last ? cnt + 1'b1 : '0;
    ndiv = state == STOP && acc_ok ? cfg_div : last && pend ? pend_div : cur_div;
    h = ({1'b0, ndiv} + 1'b1) >> 1;
  end
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state <= STOP;
      cnt <= '0;
      cur_div <= CNT_W'(DEF_DIV);
      pend <= 1'b0;
      pend_div <= '0;
      clk_out <= 1'b0;
      div_tick <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
      cur_div <= ndiv;
      clk_out <= nstate != STOP && {1'b0, ncnt} < h;
      div_tick <= nstate != STOP && ncnt == ndiv - 1'b1;
      cfg_err <= acc && cfg_div < CNT_W'(2);
      // A change accepted in the boundary cycle itself waits a full period,
      // since acceptance requires no pending change to be in flight.
      if (last && pend) pend <= 1'b0;
      if (acc_ok && run) begin
        pend <= 1'b1;
        pend_div <= cfg_div;
      end
    end
  end
endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;
  logic clk_in = 1'b0;
  logic rst, en, cfg_valid;
  logic [7:0] cfg_div, cur_div;
  logic cfg_ready, clk_out, div_tick, busy, cfg_err;
  int total = 0;
  int bad = 0;

  clk_div_ctrl #(.CNT_W(8), .DEF_DIV(5)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .clk_out(clk_out), .div_tick(div_tick), .busy(busy),
    .cur_div(cur_div), .cfg_err(cfg_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic e, v;
    logic [7:0] d;
    logic co, tk, bz, rdy;
    logic [7:0] cd;
    logic er;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic e, v, input logic [7:0] d, input logic co, tk, bz, rdy,
                     input logic [7:0] cd, input logic er);
    vec_t x;
    x.e = e; x.v = v; x.d = d; x.co = co; x.tk = tk; x.bz = bz; x.rdy = rdy; x.cd = cd; x.er = er;
    tv.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    int hi, tk, tkpos, n;
    bit found;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    // en, valid, div -> clk_out, div_tick, busy, cfg_ready, cur_div, cfg_err
    add(1,0,0, 1,0,1,1,5,0); add(1,0,0, 1,0,1,1,5,0); add(1,0,0, 1,0,1,1,5,0);
    add(1,0,0, 0,0,1,1,5,0); add(1,0,0, 0,1,1,1,5,0); add(1,0,0, 1,0,1,1,5,0);
    add(1,0,0, 1,0,1,1,5,0);
    add(1,1,4, 1,0,1,0,5,0); add(1,1,7, 0,0,1,0,5,0); add(1,1,7, 0,1,1,0,5,0);
    add(1,1,7, 1,0,1,1,4,0); add(1,1,7, 1,0,1,0,4,0); add(1,0,0, 0,0,1,0,4,0);
    add(1,0,0, 0,1,1,0,4,0); add(1,0,0, 1,0,1,1,7,0);
    add(1,0,0, 1,0,1,1,7,0); add(1,0,0, 1,0,1,1,7,0); add(1,0,0, 1,0,1,1,7,0);
    add(1,0,0, 0,0,1,1,7,0); add(1,0,0, 0,0,1,1,7,0); add(1,0,0, 0,1,1,1,7,0);
    add(1,0,0, 1,0,1,1,7,0);
    add(1,1,1, 1,0,1,1,7,1); add(1,1,0, 1,0,1,1,7,1); add(1,0,0, 1,0,1,1,7,0);
    add(0,0,0, 0,0,1,1,7,0); add(0,0,0, 0,0,1,1,7,0); add(0,0,0, 0,1,1,1,7,0);
    add(0,0,0, 0,0,0,1,7,0);
    add(0,1,5, 0,0,0,1,5,0);
    add(1,1,2, 1,0,1,1,2,0); add(1,0,0, 0,1,1,1,2,0); add(1,0,0, 1,0,1,1,2,0);
    add(0,0,0, 0,1,1,1,2,0); add(0,0,0, 0,0,0,1,2,0);
    add(1,1,5, 1,0,1,1,5,0); add(1,0,0, 1,0,1,1,5,0); add(0,0,0, 1,0,1,1,5,0);
    add(1,0,0, 0,0,1,1,5,0); add(1,0,0, 0,1,1,1,5,0); add(1,0,0, 1,0,1,1,5,0);

    repeat (2) @(posedge clk_in);
    #1 rst = 1'b0;
    chk("rst clk_out", clk_out, 0); chk("rst busy", busy, 0); chk("rst div_tick", div_tick, 0);
    chk("rst cfg_ready", cfg_ready, 1); chk("rst cur_div", cur_div, 5); chk("rst cfg_err", cfg_err, 0);

    foreach (tv[i]) begin
      en = tv[i].e; cfg_valid = tv[i].v; cfg_div = tv[i].d;
      step();
      chk($sformatf("v%0d clk_out", i), clk_out, tv[i].co);
      chk($sformatf("v%0d div_tick", i), div_tick, tv[i].tk);
      chk($sformatf("v%0d busy", i), busy, tv[i].bz);
      chk($sformatf("v%0d cfg_ready", i), cfg_ready, tv[i].rdy);
      chk($sformatf("v%0d cur_div", i), cur_div, tv[i].cd);
      chk($sformatf("v%0d cfg_err", i), cfg_err, tv[i].er);
    end

    // maximum ratio: high 128, low 127, one tick in the last cycle
    cfg_valid = 1'b1; cfg_div = 8'd255;
    step();
    cfg_valid = 1'b0;
    chk("n255 pending ready", cfg_ready, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (cur_div == 8'd255) found = 1;
      else step();
    end
    chk("n255 reached", found, 1);
    hi = 0; tk = 0; tkpos = -1;
    for (int i = 0; i < 255; i++) begin
      if (i > 0) step();
      hi += clk_out;
      if (div_tick) begin tk++; tkpos = i; end
    end
    chk("n255 high cycles", hi, 128);
    chk("n255 ticks", tk, 1);
    chk("n255 tick position", tkpos, 254);
    step();
    chk("n255 next period high", clk_out, 1);

    // async reset mid-high with a change pending
    step(); step();
    cfg_valid = 1'b1; cfg_div = 8'd9;
    step();
    cfg_valid = 1'b0;
    chk("pre-rst cfg_ready", cfg_ready, 0);
    chk("pre-rst clk_out", clk_out, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst clk_out", clk_out, 0); chk("arst busy", busy, 0); chk("arst div_tick", div_tick, 0);
    chk("arst cfg_ready", cfg_ready, 1); chk("arst cur_div", cur_div, 5);
    en = 1'b0;
    #10 rst = 1'b0;
    step();
    chk("post-rst busy", busy, 0); chk("post-rst cur_div", cur_div, 5); chk("post-rst cfg_ready", cfg_ready, 1);
    en = 1'b1;
    n = 0;
    repeat (5) begin step(); n += clk_out; end
    chk("post-rst high count", n, 3);
    chk("post-rst tick", div_tick, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
